// File: rtl/local_nic_if.sv
// Bundle of the core-side and router-side signals of the node network interface.
// The NIC takes the slave modport; the core/router side takes the master modport.
`ifndef WIDTH_PORT
`define WIDTH_PORT 32
`endif
`ifndef WIDTH_PV
`define WIDTH_PV 5
`endif

interface local_nic_if #(
    parameter int FLIT_W = `WIDTH_PORT,
    parameter int PV_W   = `WIDTH_PV
);
    logic              core_tx_valid;
    logic              core_tx_ready;
    logic [FLIT_W-1:0] core_tx_flit;
    logic [PV_W-1:0]   core_tx_pv;
    logic [FLIT_W-1:0] dinLocal;
    logic [PV_W-1:0]   PVLocal;
    logic              injAck;
    logic [FLIT_W-1:0] localOut;
    logic              core_rx_valid;
    logic              core_rx_ready;
    logic [FLIT_W-1:0] core_rx_flit;
    logic              starve;
    logic              ej_overflow;
    logic [7:0]        ej_drop_cnt;

    modport slave (
        input  core_tx_valid, core_tx_flit, core_tx_pv, injAck, localOut, core_rx_ready,
        output core_tx_ready, dinLocal, PVLocal, core_rx_valid, core_rx_flit,
               starve, ej_overflow, ej_drop_cnt
    );

    modport master (
        output core_tx_valid, core_tx_flit, core_tx_pv, injAck, localOut, core_rx_ready,
        input  core_tx_ready, dinLocal, PVLocal, core_rx_valid, core_rx_flit,
               starve, ej_overflow, ej_drop_cnt
    );
endinterface

// File: rtl/local_nic.sv
// Node-side NIC for the deflection router: injection FIFO feeding dinLocal/PVLocal,
// ejection FIFO capturing localOut, plus starvation and ejection-drop tracking.
`ifndef WIDTH_PORT
`define WIDTH_PORT 32
`endif
`ifndef WIDTH_PV
`define WIDTH_PV 5
`endif

module local_nic #(
    parameter int FLIT_W    = `WIDTH_PORT,
    parameter int PV_W      = `WIDTH_PV,
    parameter int INJ_DEPTH = 4,
    parameter int EJ_DEPTH  = 4,
    parameter int STARVE_TH = 15
) (
    input  logic       clk,
    input  logic       reset,
    local_nic_if.slave bus
);
    localparam int IAW = $clog2(INJ_DEPTH);
    localparam int EAW = $clog2(EJ_DEPTH);
    localparam logic [IAW:0] INJ_FULL = INJ_DEPTH[IAW:0];
    localparam logic [EAW:0] EJ_FULL  = EJ_DEPTH[EAW:0];
    localparam logic [7:0]   STARVE_LIM = STARVE_TH[7:0];
    localparam logic [FLIT_W-1:0] VALID_BIT = {1'b1, {(FLIT_W-1){1'b0}}};

    // ---------------- injection side ----------------
    logic [FLIT_W-1:0] r_inj_flit [INJ_DEPTH];
    logic [PV_W-1:0]   r_inj_pv   [INJ_DEPTH];
    logic [IAW-1:0]    r_inj_wr, r_inj_rd;
    logic [IAW:0]      r_inj_cnt;
    logic [7:0]        r_starve_cnt;

    logic w_inj_empty, w_inj_full, w_inj_push, w_inj_pop;

    assign w_inj_empty = (r_inj_cnt == '0);
    assign w_inj_full  = (r_inj_cnt == INJ_FULL);
    // No full-bypass: a pop in the same cycle does not open a slot for the push.
    assign w_inj_push  = bus.core_tx_valid & ~w_inj_full;
    assign w_inj_pop   = bus.injAck & ~w_inj_empty;

    always_ff @(posedge clk) begin
        if (w_inj_push) begin
            r_inj_flit[r_inj_wr] <= bus.core_tx_flit;
            r_inj_pv[r_inj_wr]   <= bus.core_tx_pv;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_inj_wr  <= '0;
            r_inj_rd  <= '0;
            r_inj_cnt <= '0;
        end else begin
            if (w_inj_push) r_inj_wr <= r_inj_wr + 1'b1;
            if (w_inj_pop)  r_inj_rd <= r_inj_rd + 1'b1;
            case ({w_inj_push, w_inj_pop})
                2'b10:   r_inj_cnt <= r_inj_cnt + 1'b1;
                2'b01:   r_inj_cnt <= r_inj_cnt - 1'b1;
                default: r_inj_cnt <= r_inj_cnt;
            endcase
        end
    end

    // Age of the presented head; restarts whenever the head changes or leaves.
    always_ff @(posedge clk) begin
        if (reset || w_inj_pop || w_inj_empty) begin
            r_starve_cnt <= '0;
        end else if (r_starve_cnt != 8'hFF) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    assign bus.core_tx_ready = ~w_inj_full;
    assign bus.dinLocal      = w_inj_empty ? '0 : (r_inj_flit[r_inj_rd] | VALID_BIT);
    assign bus.PVLocal       = w_inj_empty ? '0 : r_inj_pv[r_inj_rd];
    assign bus.starve        = (r_starve_cnt >= STARVE_LIM);

    // ---------------- ejection side ----------------
    logic [FLIT_W-1:0] r_ej_flit [EJ_DEPTH];
    logic [EAW-1:0]    r_ej_wr, r_ej_rd;
    logic [EAW:0]      r_ej_cnt;
    logic              r_ej_overflow;
    logic [7:0]        r_ej_drop_cnt;

    logic w_ej_empty, w_ej_full, w_ej_in, w_ej_rd, w_ej_wr, w_ej_drop;

    assign w_ej_empty = (r_ej_cnt == '0);
    assign w_ej_full  = (r_ej_cnt == EJ_FULL);
    assign w_ej_in    = bus.localOut[FLIT_W-1];
    assign w_ej_rd    = ~w_ej_empty & bus.core_rx_ready;
    // The router cannot be stalled, so a same-cycle read frees the slot for the write.
    assign w_ej_wr    = w_ej_in & (~w_ej_full | w_ej_rd);
    assign w_ej_drop  = w_ej_in & w_ej_full & ~w_ej_rd;

    always_ff @(posedge clk) begin
        if (w_ej_wr) r_ej_flit[r_ej_wr] <= bus.localOut;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ej_wr       <= '0;
            r_ej_rd       <= '0;
            r_ej_cnt      <= '0;
            r_ej_overflow <= 1'b0;
            r_ej_drop_cnt <= '0;
        end else begin
            if (w_ej_wr) r_ej_wr <= r_ej_wr + 1'b1;
            if (w_ej_rd) r_ej_rd <= r_ej_rd + 1'b1;
            case ({w_ej_wr, w_ej_rd})
                2'b10:   r_ej_cnt <= r_ej_cnt + 1'b1;
                2'b01:   r_ej_cnt <= r_ej_cnt - 1'b1;
                default: r_ej_cnt <= r_ej_cnt;
            endcase
            if (w_ej_drop) begin
                r_ej_overflow <= 1'b1;
                if (r_ej_drop_cnt != 8'hFF) r_ej_drop_cnt <= r_ej_drop_cnt + 1'b1;
            end
        end
    end

    assign bus.core_rx_valid = ~w_ej_empty;
    assign bus.core_rx_flit  = w_ej_empty ? '0 : r_ej_flit[r_ej_rd];
    assign bus.ej_overflow   = r_ej_overflow;
    assign bus.ej_drop_cnt   = r_ej_drop_cnt;
endmodule

// File: doc/local_nic.md
# local_nic

Node-side network interface for the bufferless deflection router. It is the other end of the router's local eject/inject stage. It queues core flits and offers the head flit to the router as `dinLocal` with its productive-port vector `PVLocal`, and pops the head when the router reports an injection. It also captures every flit the router ejects on `localOut` into an ejection FIFO that the core drains with a valid/ready handshake. Because the router cannot stall ejection, ejection overflow is counted and flagged, never back-pressured.

## Interface
- `FLIT_W`, default `` `WIDTH_PORT ``: flit width. Bit `FLIT_W-1` is the flit valid bit.
- `PV_W`, default `` `WIDTH_PV ``: productive-port vector width (5).
- `INJ_DEPTH`, default 4: injection FIFO entries. Power of 2, ≥2.
- `EJ_DEPTH`, default 4: ejection FIFO entries. Power of 2, ≥2.
- `STARVE_TH`, default 15: number of consecutive un-injected cycles after which `starve` asserts. Range 1..255.
- `clk` in 1: clock. All state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `core_tx_valid` in 1: core offers a flit for injection.
- `core_tx_ready` out 1: injection FIFO can accept a flit.
- `core_tx_flit` in FLIT_W: flit to inject.
- `core_tx_pv` in PV_W: productive ports for that flit.
- `dinLocal` out FLIT_W: head injection flit, or all-zero when empty.
- `PVLocal` out PV_W: head flit PV, or 0 when empty.
- `injAck` in 1: router injected `dinLocal` this cycle (OR of its inject vector).
- `localOut` in FLIT_W: ejected flit from the router. Valid iff bit `FLIT_W-1` = 1.
- `core_rx_valid` out 1: ejection FIFO non-empty.
- `core_rx_ready` in 1: core accepts the ejection head.
- `core_rx_flit` out FLIT_W: ejection FIFO head.
- `starve` out 1: the head has waited ≥ STARVE_TH cycles.
- `ej_overflow` out 1: sticky flag. An ejected flit was dropped.
- `ej_drop_cnt` out 8: count of dropped ejected flits, saturating at 255.

## Operation
- Injection FIFO: circular buffer with wr_ptr and rd_ptr, plus a count of width log2(INJ_DEPTH)+1.
  - Push when `core_tx_valid & core_tx_ready`.
  - Pop when `injAck & (count != 0)`.
  - `core_tx_ready = (count != INJ_DEPTH)`. The FIFO has no full-bypass, so a push to a full FIFO is blocked even when a pop happens in the same cycle.
  - Simultaneous push and pop on a non-full, non-empty FIFO leaves count unchanged.
  - Pointers wrap modulo the depth.
  - `injAck` while empty is ignored. It causes no state change.
- Head presentation:
  - `dinLocal` = head entry with bit `FLIT_W-1` forced to 1 when count != 0, else all-zero.
  - `PVLocal` = head PV when count != 0, else 0.
  - Both are registered-data reads with no combinational path from `core_tx_*`.
- Starvation counter (8 bits):
  - Cleared on reset, on pop, and whenever the FIFO is empty.
  - Otherwise increments by 1 each cycle the head is present and `injAck` = 0, saturating at 255.
  - `starve = (starve_cnt >= STARVE_TH)`. The comparison is combinational from the register.
- Ejection FIFO: same structure as the injection FIFO.
  - Write when `localOut[FLIT_W-1]`. The flit is stored unchanged.
  - Read when `core_rx_valid & core_rx_ready`.
  - When the FIFO is full with a valid `localOut` and a read occurs in the same cycle, the write succeeds (read frees the slot first).
  - When the FIFO is full with a valid `localOut` and no read occurs, the flit is dropped: `ej_overflow` ← 1 and `ej_drop_cnt` increments, saturating at 255.
- `ej_overflow` and `ej_drop_cnt` are cleared only by reset.

## Timing
- Reset values, in effect the cycle after `reset` is sampled high:
  - Both FIFOs empty, all pointers and counts 0.
  - `core_tx_ready` = 1, `dinLocal` = 0, `PVLocal` = 0, `core_rx_valid` = 0, `core_rx_flit` = 0.
  - `starve` = 0, `ej_overflow` = 0, `ej_drop_cnt` = 0.
- `reset` overrides all other activity in the same cycle. In-flight FIFO contents are discarded.
- Injection latency: a flit pushed at edge N appears on `dinLocal` after edge N, i.e. in cycle N+1. There is no same-cycle pass-through.
- `injAck` is sampled in the same cycle that `dinLocal` is valid. The pop takes effect at that edge, and the next entry (if any) is presented the following cycle.
- Ejection latency: a valid `localOut` in cycle N makes `core_rx_valid` = 1 from cycle N+1.
- Throughput: one push and one pop per FIFO per cycle.

## Test plan
- Reset mid-operation: push 3 flits, assert `reset` for 1 cycle. Next cycle: `core_tx_ready` = 1, `dinLocal` = 0, `core_rx_valid` = 0, `ej_drop_cnt` = 0.
- Injection order and latency:
  - Push A, B, C, D back-to-back with `injAck` = 0. Then `core_tx_ready` = 0 and `dinLocal` = A with MSB set.
  - Pulse `injAck` on 4 cycles. `dinLocal` shows B, C, D, then 0, and `core_tx_ready` returns to 1 after the first ack.
- Starvation: hold one flit with `injAck` = 0 and STARVE_TH = 15.
  - `starve` rises in the 16th cycle after presentation.
  - One `injAck` clears `starve` in the next cycle.
- Full-FIFO push with concurrent pop: on a full injection FIFO, set `core_tx_valid` = 1 and `injAck` = 1 in the same cycle. The push is blocked and the count becomes 3.
- Ejection overflow: hold `core_rx_ready` = 0 and drive 6 valid `localOut` flits.
  - 4 are stored and 2 are dropped: `ej_drop_cnt` = 2, `ej_overflow` = 1.
  - Drain with `core_rx_ready` = 1: the 4 flits emerge in order, and the flag stays 1.
- Full ejection FIFO with read and write in the same cycle: the new flit is stored, the count stays at 4, and `ej_drop_cnt` does not change.
